// File: rtl/enc_pkg.sv
// enc_pkg: shared one-hot/binary widths and types for the select-bus encoder and decoder
package enc_pkg;
  localparam int ONEHOT_W = 15;
  localparam int BIN_W = 4;
  localparam logic [BIN_W-1:0] NONE_CODE = 4'hF;
  localparam int ERR_CNT_W = 8;
  typedef logic [ONEHOT_W-1:0] onehot_t;
  typedef logic [BIN_W-1:0] bin_t;
  typedef logic [ERR_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/onehot_chk.sv
// onehot_chk: lowest-set-bit priority encoder with zero-hot and multi-hot detection
module onehot_chk
  import enc_pkg::*;
(
  input  onehot_t v,
  output bin_t    idx,
  output logic    none,
  output logic    multi
);
  // scan from the top so the lowest set bit wins; empty word yields the reserved code
  always_comb begin
    idx = NONE_CODE;
    for (int i = ONEHOT_W - 1; i >= 0; i--) idx = v[i] ? bin_t'(i) : idx;
    none = v == '0;
    multi = |(v & (v - onehot_t'(1)));
  end
endmodule

// File: rtl/dec_onehot2bin.sv
// dec_onehot2bin: two-stage valid/ready one-hot to binary decoder with error flag and counter
module dec_onehot2bin
  import enc_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  output logic    in_ready,
  input  onehot_t in_onehot,
  output logic    out_valid,
  input  logic    out_ready,
  output bin_t    out_bin,
  output logic    out_err,
  output cnt_t    err_cnt,
  input  logic    err_clr
);
  logic    s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, err_q, err_d, s2_load;
  onehot_t s1_data_q, s1_data_d;
  bin_t    bin_q, bin_d, idx;
  cnt_t    cnt_q, cnt_d;
  logic    none, multi;
  onehot_chk u_chk (.v(s1_data_q), .idx(idx), .none(none), .multi(multi));
  // handshake: stage 1 accepts whenever it is empty or can move into stage 2
  always_comb begin
    in_ready = !s1_valid_q | !s2_valid_q | out_ready;
    s2_load = s1_valid_q & (!s2_valid_q | out_ready);
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_data_d = (in_ready & in_valid) ? in_onehot : s1_data_q;
    s2_valid_d = s2_load | (s2_valid_q & !out_ready);
    bin_d = s2_load ? idx : bin_q;
    err_d = s2_load ? (none | multi) : err_q;
    cnt_d = err_clr ? '0 : (s2_load & (none | multi) & ~&cnt_q) ? cnt_q + cnt_t'(1) : cnt_q;
  end
  // stage registers and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q <= '0;
      s2_valid_q <= 1'b0;
      bin_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      bin_q <= bin_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign out_bin = bin_q;
  assign out_err = err_q;
  assign err_cnt = cnt_q;
endmodule

// File: tb/tb_dec_onehot2bin.sv
// tb_dec_onehot2bin: table-driven scoreboard bench for the one-hot decoder
module tb_dec_onehot2bin;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, err_clr = 0;
  logic in_ready, out_valid, out_err;
  logic [14:0] in_onehot = '0;
  logic [3:0] out_bin;
  logic [7:0] err_cnt;
  dec_onehot2bin dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_onehot(in_onehot), .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_err(out_err), .err_cnt(err_cnt), .err_clr(err_clr));
  always #5 clk = ~clk;
  typedef struct { logic [14:0] w; logic [3:0] b; logic e; } vec_t;
  typedef struct { logic [3:0] b; logic e; int acc; bit lat; } exp_t;
  vec_t tbl[22];
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, m_cnt = 0;
  bit saw_stall = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && !in_ready) saw_stall = 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask
  // output monitor: every transfer or stalled hold must match the scoreboard head
  always @(negedge clk) if (!rst && out_valid) begin
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL spurious_out got bin %0h err %0b expected no output", out_bin, out_err);
    end else begin
      chk("out_bin", out_bin, q[0].b);
      chk("out_err", out_err, q[0].e);
      if (q[0].lat && out_ready) chk("latency", cyc - q[0].acc, 1);
      if (out_ready) void'(q.pop_front());
    end
  end
  task automatic send(input logic [14:0] w, input logic [3:0] b, input logic e, input bit lat);
    int n = 0;
    in_valid = 1; in_onehot = w;
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout got in_ready 0 expected 1");
    end else begin
      q.push_back('{b, e, cyc + 1, lat});
      if (e && m_cnt != 255) m_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin n++; @(posedge clk); #1; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask
  function automatic logic [14:0] enc(input int v);
    logic [14:0] one = 15'd1;
    return v < 15 ? one << v : 15'd0;
  endfunction
  initial begin
    for (int i = 0; i < 15; i++) tbl[i] = '{enc(i), 4'(i), 1'b0};
    tbl[15] = '{15'h0000, 4'hF, 1'b1};
    tbl[16] = '{15'h0014, 4'd2, 1'b1};
    tbl[17] = '{15'h7FFF, 4'd0, 1'b1};
    tbl[18] = '{15'h6000, 4'd13, 1'b1};
    tbl[19] = '{15'h4001, 4'd0, 1'b1};
    tbl[20] = '{15'h0300, 4'd8, 1'b1};
    tbl[21] = '{15'h4000, 4'd14, 1'b0};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    for (int i = 0; i < 15; i++) send(tbl[i].w, tbl[i].b, tbl[i].e, 1);
    drain();
    chk("sweep_err_cnt", err_cnt, 0);
    send(tbl[15].w, tbl[15].b, tbl[15].e, 1);
    drain();
    chk("zero_hot_cnt", err_cnt, 1);
    send(tbl[16].w, tbl[16].b, tbl[16].e, 1);
    drain();
    chk("multi_hot_cnt", err_cnt, 2);
    for (int i = 17; i < 22; i++) send(tbl[i].w, tbl[i].b, tbl[i].e, 0);
    drain();
    chk("table_cnt", err_cnt, m_cnt);
    saw_stall = 0;
    fork
      for (int i = 0; i < 5; i++) send(tbl[i].w, tbl[i].b, tbl[i].e, 0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    chk("stall_in_ready_fell", saw_stall, 1);
    for (int i = 0; i < 300; i++) send(15'h0, 4'hF, 1'b1, 0);
    drain();
    chk("sat_cnt", err_cnt, 255);
    chk("sat_model", m_cnt, 255);
    send(15'h0, 4'hF, 1'b1, 0);
    drain();
    chk("sat_hold", err_cnt, 255);
    send(15'h0, 4'hF, 1'b1, 0);
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    m_cnt = 0;
    drain();
    chk("clr_priority", err_cnt, 0);
    send(15'h0, 4'hF, 1'b1, 0);
    drain();
    chk("after_clr_cnt", err_cnt, 1);
    out_ready = 0;
    send(15'h0, 4'hF, 1'b1, 0);
    send(15'h0008, 4'd3, 1'b0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    m_cnt = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    for (int v = 0; v < 16; v++) send(enc(v), v < 15 ? 4'(v) : 4'hF, v == 15, 1);
    drain();
    chk("e2e_err_cnt", err_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end
endmodule
